// File: rtl/pr3_stream_pkg.sv
// rtl/pr3_stream_pkg.sv - shared stream constants and accumulator state type
//
// Default sizes for the acquisition chain (sample buffer and batch accumulator)
// and the batch accumulator FSM state encoding.

package pr3_stream_pkg;

    localparam int DATA_WIDTH_DEF = 14;
    localparam int BATCH_SIZE_DEF = 2048;
    localparam int RUNS_DEF       = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SOP = 3'd1,
        ST_RECV     = 3'd2,
        ST_FLUSH    = 3'd3,
        ST_DONE     = 3'd4
    } acc_state_e;

endpackage

// File: rtl/batch_acc_ram.sv
// rtl/batch_acc_ram.sv - accumulator storage, one write port and two async read ports
//
// Ports:
//   clk              write clock
//   we/waddr/wdata   synchronous write port
//   raddr_a/rdata_a  async read for the read-modify-write path
//   raddr_b/rdata_b  async read for readout; addresses beyond DEPTH read as zero
//
// The array is deliberately not reset: the first run of every acquisition
// overwrites each entry, so no clear sweep is required.

module batch_acc_ram #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 16,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];

    generate
        if (DEPTH == (1 << AW)) begin : g_full_range
            assign rdata_b = mem[raddr_b];
        end else begin : g_partial_range
            // Non-power-of-two depth: the address space has holes that read as zero.
            assign rdata_b = (int'(raddr_b) < DEPTH) ? mem[raddr_b] : '0;
        end
    endgenerate

endmodule

// File: rtl/batch_accumulator.sv
// rtl/batch_accumulator.sv - sums RUNS framed packets entry-wise with a readout port
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   start            pulse: arm a new acquisition (also aborts one in flight)
//   busy/done/error  status; error is sticky until the next start
//   sink_*           sop/eop/valid/data packet stream, no backpressure
//   rd_addr/rd_data  registered readout of the summed batch, 1-cycle latency
//
// BATCH_SIZE must be >= 2 and RUNS >= 1.

module batch_accumulator
    import pr3_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BATCH_SIZE = BATCH_SIZE_DEF,
    parameter int RUNS       = RUNS_DEF
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    start,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    error,
    input  logic                                    sink_sop,
    input  logic                                    sink_eop,
    input  logic                                    sink_valid,
    input  logic signed [DATA_WIDTH-1:0]            sink_data,
    input  logic [$clog2(BATCH_SIZE)-1:0]           rd_addr,
    output logic signed [DATA_WIDTH+$clog2(RUNS)-1:0] rd_data
);

    localparam int ACC_WIDTH = DATA_WIDTH + $clog2(RUNS);
    localparam int AW        = $clog2(BATCH_SIZE);
    localparam int RCW       = $clog2(RUNS + 1);

    localparam logic [AW-1:0]  LAST_POS = AW'(BATCH_SIZE - 1);
    localparam logic [RCW-1:0] LAST_RUN = RCW'(RUNS - 1);

    acc_state_e                   state_q, state_d;
    logic [AW-1:0]                pos_q, pos_d;
    logic [RCW-1:0]               run_cnt_q, run_cnt_d;
    logic                         error_q, error_d;

    logic                         s1_valid_q, s1_valid_d;
    logic signed [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic [AW-1:0]                s1_idx_q, s1_idx_d;
    logic                         s1_first_q, s1_first_d;

    logic [ACC_WIDTH-1:0]         rd_data_q, rd_data_d;

    logic signed [ACC_WIDTH-1:0]  s1_sext;
    logic [ACC_WIDTH-1:0]         rmw_data;
    logic [ACC_WIDTH-1:0]         wr_data;
    logic [ACC_WIDTH-1:0]         rd_word;

    // Control: FSM, position/run counters and framing checks.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        run_cnt_d  = run_cnt_q;
        error_d    = error_q;
        s1_valid_d = 1'b0;
        s1_data_d  = sink_data;
        s1_idx_d   = pos_q;
        s1_first_d = (run_cnt_q == '0);

        if (start) begin
            state_d   = ST_WAIT_SOP;
            pos_d     = '0;
            run_cnt_d = '0;
            error_d   = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_SOP: begin
                    if (sink_valid && sink_sop) begin
                        if (sink_eop) begin
                            // A one-beat packet can never be a full batch.
                            state_d = ST_IDLE;
                            error_d = 1'b1;
                            pos_d   = '0;
                        end else begin
                            s1_valid_d = 1'b1;
                            s1_idx_d   = '0;
                            pos_d      = AW'(1);
                            state_d    = ST_RECV;
                        end
                    end
                end
                ST_RECV: begin
                    if (sink_valid) begin
                        // eop must coincide exactly with the last index.
                        if (sink_sop || (sink_eop != (pos_q == LAST_POS))) begin
                            state_d = ST_IDLE;
                            error_d = 1'b1;
                            pos_d   = '0;
                        end else begin
                            s1_valid_d = 1'b1;
                            if (sink_eop) begin
                                pos_d     = '0;
                                run_cnt_d = run_cnt_q + 1'b1;
                                state_d   = (run_cnt_q == LAST_RUN) ? ST_FLUSH : ST_WAIT_SOP;
                            end else begin
                                pos_d = pos_q + 1'b1;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    // The final entry is written on this edge; results are complete afterwards.
                    state_d = ST_DONE;
                end
                default: begin
                end
            endcase
        end
    end

    // S2: the first run overwrites, later runs add onto the stored partial sum.
    always_comb begin
        s1_sext = ACC_WIDTH'(s1_data_q);
        wr_data = s1_first_q ? s1_sext : (rmw_data + s1_sext);
    end

    always_comb begin
        rd_data_d = rd_word;
    end

    batch_acc_ram #(
        .DEPTH (BATCH_SIZE),
        .WIDTH (ACC_WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (s1_valid_q),
        .waddr   (s1_idx_q),
        .wdata   (wr_data),
        .raddr_a (s1_idx_q),
        .rdata_a (rmw_data),
        .raddr_b (rd_addr),
        .rdata_b (rd_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pos_q      <= '0;
            run_cnt_q  <= '0;
            error_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_idx_q   <= '0;
            s1_first_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            run_cnt_q  <= run_cnt_d;
            error_q    <= error_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_idx_q   <= s1_idx_d;
            s1_first_q <= s1_first_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign busy    = (state_q == ST_WAIT_SOP) || (state_q == ST_RECV) || (state_q == ST_FLUSH);
    assign done    = (state_q == ST_DONE);
    assign error   = error_q;
    assign rd_data = rd_data_q;

endmodule
